// File: rtl/instr_program_loader_pkg.sv
// Shared RV32I encoding constants, request opcodes and payload types for the program loader.
// The core's control decoder imports the same constants so both directions stay in step.
package instr_program_loader_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F7_W     = 7;
    localparam int unsigned OP_W     = 4;

    // Major opcodes
    localparam logic [OPCODE_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;

    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_LW   = 3'b010;
    localparam logic [F3_W-1:0] F3_SW   = 3'b010;
    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_JALR = 3'b000;

    localparam logic [F7_W-1:0] F7_ZERO = 7'b0000000;
    localparam logic [F7_W-1:0] F7_SUB  = 7'b0100000;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_ADDI = 4'd6,  OP_ANDI = 4'd7,
        OP_ORI  = 4'd8,  OP_XORI = 4'd9,  OP_LW   = 4'd10, OP_SW   = 4'd11,
        OP_BEQ  = 4'd12, OP_JAL  = 4'd13, OP_JALR = 4'd14, OP_LUI  = 4'd15
    } req_op_e;

    typedef struct packed {
        req_op_e          op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_program_loader_encoder.sv
// Combinational RV32I encoder: symbolic request in, 32-bit instruction word out.
module instr_encoder
    import instr_program_loader_pkg::*;
(
    input  req_t            req,
    output logic [XLEN-1:0] word_c
);

    always_comb begin
        word_c = '0;
        case (req.op)
            OP_ADD:  word_c = {F7_ZERO, req.rs2, req.rs1, F3_ADD, req.rd, OPC_R};
            OP_SUB:  word_c = {F7_SUB,  req.rs2, req.rs1, F3_ADD, req.rd, OPC_R};
            OP_AND:  word_c = {F7_ZERO, req.rs2, req.rs1, F3_AND, req.rd, OPC_R};
            OP_OR:   word_c = {F7_ZERO, req.rs2, req.rs1, F3_OR,  req.rd, OPC_R};
            OP_XOR:  word_c = {F7_ZERO, req.rs2, req.rs1, F3_XOR, req.rd, OPC_R};
            OP_SLT:  word_c = {F7_ZERO, req.rs2, req.rs1, F3_SLT, req.rd, OPC_R};
            OP_ADDI: word_c = {req.imm[11:0], req.rs1, F3_ADD,  req.rd, OPC_I_ALU};
            OP_ANDI: word_c = {req.imm[11:0], req.rs1, F3_AND,  req.rd, OPC_I_ALU};
            OP_ORI:  word_c = {req.imm[11:0], req.rs1, F3_OR,   req.rd, OPC_I_ALU};
            OP_XORI: word_c = {req.imm[11:0], req.rs1, F3_XOR,  req.rd, OPC_I_ALU};
            OP_LW:   word_c = {req.imm[11:0], req.rs1, F3_LW,   req.rd, OPC_LOAD};
            OP_JALR: word_c = {req.imm[11:0], req.rs1, F3_JALR, req.rd, OPC_JALR};
            OP_SW:   word_c = {req.imm[11:5], req.rs2, req.rs1, F3_SW,
                               req.imm[4:0], OPC_STORE};
            // Branch/jump offsets are even; bit 0 is never encoded
            OP_BEQ:  word_c = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                               req.imm[4:1], req.imm[11], OPC_BRANCH};
            OP_JAL:  word_c = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                               req.rd, OPC_JAL};
            OP_LUI:  word_c = {req.imm[31:12], req.rd, OPC_LUI};
            default: word_c = '0;
        endcase
    end

endmodule

// File: rtl/instr_program_loader.sv
// Boot-path program loader: encodes requests and writes them sequentially into
// instruction memory while holding the core in reset.
module instr_program_loader
    import instr_program_loader_pkg::*;
#(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [REG_W-1:0]  req_rd,
    input  logic [REG_W-1:0]  req_rs1,
    input  logic [REG_W-1:0]  req_rs2,
    input  logic [XLEN-1:0]   req_imm,
    output logic              imem_we,
    output logic [AW-1:0]     imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [AW:0]       count,
    output logic              overflow
);

    localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    state_e          state;
    logic [AW:0]     wr_ptr;      // words accepted this session
    req_t            req;
    logic [XLEN-1:0] enc_word_c;
    logic            accept_c;

    assign req = '{op: req_op_e'(req_op), rd: req_rd, rs1: req_rs1,
                   rs2: req_rs2, imm: req_imm};

    instr_encoder u_encoder (
        .req    (req),
        .word_c (enc_word_c)
    );

    assign req_ready = (state == S_LOAD) && (wr_ptr < PTR_FULL);
    assign accept_c  = req_valid && req_ready;

    // Session FSM plus write pipeline; count tracks completed writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= accept_c;
            done    <= 1'b0;
            if (accept_c) begin
                imem_addr  <= wr_ptr[AW-1:0];
                imem_wdata <= enc_word_c;
                wr_ptr     <= wr_ptr + PTR_ONE;
            end
            if (imem_we) begin
                count <= count + PTR_ONE;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        wr_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (req_valid && !req_ready) begin
                        overflow <= 1'b1;
                    end
                    if (finish) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_program_loader.sv
// Self-checking bench: hand-encoded vector table, directed corner sequences and
// randomized sessions against a cycle-level reference model, on DEPTH=256 and DEPTH=4 copies.
module tb_instr_program_loader;
    import instr_program_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, req_valid;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;

    logic        b_ready, b_we, b_hold, b_done, b_ovf;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [8:0]  b_count;
    logic        s_ready, s_we, s_hold, s_done, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_program_loader #(.DEPTH(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(b_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .cpu_hold(b_hold), .done(b_done), .count(b_count), .overflow(b_ovf)
    );

    instr_program_loader #(.DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(s_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .cpu_hold(s_hold), .done(s_done), .count(s_count), .overflow(s_ovf)
    );

    // Reference encoder built from field positions with shifts and masks
    function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
        logic [31:0] r, regs_r, regs_i;
        logic [31:0] f3;
        regs_r = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7);
        regs_i = (32'(rs1) << 15) | (32'(rd) << 7);
        case (op)
            4'd0, 4'd6: f3 = 0;
            4'd1:       f3 = 0;
            4'd2, 4'd7: f3 = 7;
            4'd3, 4'd8: f3 = 6;
            4'd4, 4'd9: f3 = 4;
            default:    f3 = 2;
        endcase
        case (op)
            4'd0, 4'd2, 4'd3, 4'd4, 4'd5: r = regs_r | (f3 << 12) | 32'h33;
            4'd1:  r = (32'h20 << 25) | regs_r | 32'h33;
            4'd6, 4'd7, 4'd8, 4'd9: r = ((imm & 32'hFFF) << 20) | regs_i | (f3 << 12) | 32'h13;
            4'd10: r = ((imm & 32'hFFF) << 20) | regs_i | (32'd2 << 12) | 32'h03;
            4'd14: r = ((imm & 32'hFFF) << 20) | regs_i | 32'h67;
            4'd11: r = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                       | (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            4'd12: r = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                       | (32'(rs2) << 20) | (32'(rs1) << 15)
                       | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            4'd13: r = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                       | (32'(rd) << 7) | 32'h6F;
            default: r = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
        endcase
        return r;
    endfunction

    // Session-level model: phase 0 idle, 1 loading, 2 finishing
    typedef struct {
        int          phase;
        int          accepted;
        int          written;
        bit          ovf;
        bit          hold;
        bit          dn;
        bit          we;
        int          addr;
        logic [31:0] data;
    } mstate_t;

    mstate_t m_big, m_small;

    function automatic mstate_t mreset();
        mstate_t s;
        s.phase = 0; s.accepted = 0; s.written = 0; s.ovf = 0; s.hold = 0;
        s.dn = 0; s.we = 0; s.addr = 0; s.data = '0;
        return s;
    endfunction

    function automatic bit mready(input mstate_t s, input int depth);
        return (s.phase == 1) && (s.accepted < depth);
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int depth);
        mstate_t n = s;
        bit take = req_valid && mready(s, depth);
        n.we = take;
        n.dn = 0;
        if (take) begin
            n.addr = s.accepted % depth;
            n.data = ref_encode(req_op, req_rd, req_rs1, req_rs2, req_imm);
            n.accepted = s.accepted + 1;
        end
        if (s.we) n.written = s.written + 1;
        if (s.phase == 0 && start) begin
            n.phase = 1; n.accepted = 0; n.written = 0; n.ovf = 0; n.hold = 1;
        end else if (s.phase == 1) begin
            if (req_valid && !take) n.ovf = 1;
            if (finish) begin n.phase = 2; n.dn = 1; n.hold = 0; end
        end else if (s.phase == 2) begin
            n.phase = 0;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input mstate_t m, input int depth,
                             input logic ready, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic hold, input logic dn,
                             input logic [31:0] cnt, input logic ovf);
        chk({tag, ".req_ready"}, 32'(ready), 32'(mready(m, depth)));
        chk({tag, ".imem_we"},   32'(we),    32'(m.we));
        chk({tag, ".cpu_hold"},  32'(hold),  32'(m.hold));
        chk({tag, ".done"},      32'(dn),    32'(m.dn));
        chk({tag, ".count"},     cnt,        32'(m.written));
        chk({tag, ".overflow"},  32'(ovf),   32'(m.ovf));
        if (m.we) begin
            chk({tag, ".imem_addr"},  addr,  32'(m.addr));
            chk({tag, ".imem_wdata"}, wdata, m.data);
        end
    endtask

    task automatic check_both();
        check_dut("big", m_big, 256, b_ready, b_we, 32'(b_addr), b_wdata,
                  b_hold, b_done, 32'(b_count), b_ovf);
        check_dut("small", m_small, 4, s_ready, s_we, 32'(s_addr), s_wdata,
                  s_hold, s_done, 32'(s_count), s_ovf);
    endtask

    // Advance one clock: model consumes current inputs, then outputs are compared
    task automatic tick();
        mstate_t nb, ns;
        nb = mstep(m_big, 256);
        ns = mstep(m_small, 4);
        @(posedge clk);
        #1;
        m_big = nb;
        m_small = ns;
        check_both();
    endtask

    task automatic idle_inputs();
        start = 0; finish = 0; req_valid = 0;
        req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    endtask

    task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        req_valid = 1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic end_session();
        req_valid = 0; finish = 1; tick(); finish = 0; tick(); tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".req_ready"},  32'(b_ready), 0);
        chk({tag, ".imem_we"},    32'(b_we),    0);
        chk({tag, ".imem_addr"},  32'(b_addr),  0);
        chk({tag, ".imem_wdata"}, b_wdata,      0);
        chk({tag, ".cpu_hold"},   32'(b_hold),  0);
        chk({tag, ".done"},       32'(b_done),  0);
        chk({tag, ".count"},      32'(b_count), 0);
        chk({tag, ".overflow"},   32'(b_ovf),   0);
        chk({tag, ".small_we"},   32'(s_we),    0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int we_seen;
        vt[0]  = '{OP_ADD,  5'd3,  5'd1,  5'd2, 32'h0,        32'h002081B3};
        vt[1]  = '{OP_SUB,  5'd3,  5'd1,  5'd2, 32'h0,        32'h402081B3};
        vt[2]  = '{OP_ADDI, 5'd1,  5'd0,  5'd7, 32'd5,        32'h00500093};
        vt[3]  = '{OP_SW,   5'd9,  5'd1,  5'd2, 32'd8,        32'h0020A423};
        vt[4]  = '{OP_LUI,  5'd5,  5'd7,  5'd9, 32'h12345000, 32'h123452B7};
        vt[5]  = '{OP_BEQ,  5'd0,  5'd1,  5'd2, 32'hFFFFFFFC, 32'hFE208EE3};
        vt[6]  = '{OP_JAL,  5'd1,  5'd0,  5'd0, 32'd8,        32'h008000EF};
        vt[7]  = '{OP_AND,  5'd3,  5'd1,  5'd2, 32'h0,        32'h0020F1B3};
        vt[8]  = '{OP_OR,   5'd3,  5'd1,  5'd2, 32'h0,        32'h0020E1B3};
        vt[9]  = '{OP_XOR,  5'd3,  5'd1,  5'd2, 32'h0,        32'h0020C1B3};
        vt[10] = '{OP_SLT,  5'd3,  5'd1,  5'd2, 32'h0,        32'h0020A1B3};
        vt[11] = '{OP_LW,   5'd5,  5'd2,  5'd0, 32'hFFFFFFF8, 32'hFF812283};
        vt[12] = '{OP_JALR, 5'd0,  5'd1,  5'd0, 32'h0,        32'h00008067};
        vt[13] = '{OP_XORI, 5'd1,  5'd1,  5'd0, 32'hFFFFFFFF, 32'hFFF0C093};
        vt[14] = '{OP_ANDI, 5'd2,  5'd3,  5'd0, 32'h000000FF, 32'h0FF1F113};
        vt[15] = '{OP_ORI,  5'd31, 5'd31, 5'd0, 32'h000007FF, 32'h7FFFEF93};
        vt[16] = '{OP_LUI,  5'd1,  5'd0,  5'd0, 32'hABCDEFFF, 32'hABCDE0B7};
        vt[17] = '{OP_JAL,  5'd1,  5'd0,  5'd0, 32'd9,        32'h008000EF};
        vt[18] = '{OP_JAL,  5'd0,  5'd0,  5'd0, 32'hFFFFFFFE, 32'hFFFFF06F};
        vt[19] = '{OP_BEQ,  5'd0,  5'd0,  5'd0, 32'h00001000, 32'h80000063};

        rst_n = 0;
        idle_inputs();
        m_big = mreset();
        m_small = mreset();
        #12;
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1;
        tick();

        // Vector table, applied back-to-back in one session
        pulse_start();
        chk("start.cpu_hold", 32'(b_hold), 1);
        for (int i = 0; i < NV; i++) begin
            set_req(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
            tick();
            chk($sformatf("vec%0d.we", i),    32'(b_we),   1);
            chk($sformatf("vec%0d.addr", i),  32'(b_addr), 32'(i));
            chk($sformatf("vec%0d.wdata", i), b_wdata,     vt[i].exp);
        end
        end_session();
        chk("table.count", 32'(b_count), 32'(NV));

        // Five requests into the DEPTH=4 copy
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            set_req(OP_ADDI, 5'(k + 1), 5'd0, 5'd0, 32'(k));
            tick();
        end
        req_valid = 0;
        tick();
        tick();
        chk("full.count", 32'(s_count), 4);
        chk("full.overflow", 32'(s_ovf), 1);
        chk("full.req_ready", 32'(s_ready), 0);
        chk("full.big_overflow", 32'(b_ovf), 0);
        end_session();

        // Finish together with an accept
        pulse_start();
        set_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0);
        finish = 1;
        tick();
        finish = 0;
        req_valid = 0;
        chk("fin.we", 32'(b_we), 1);
        chk("fin.wdata", b_wdata, 32'h002081B3);
        chk("fin.done", 32'(b_done), 1);
        chk("fin.cpu_hold", 32'(b_hold), 0);
        tick();
        chk("fin.done_low", 32'(b_done), 0);
        chk("fin.count", 32'(b_count), 1);
        tick();

        // Reset mid-session with a write in flight
        pulse_start();
        set_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        tick();
        tick();
        rst_n = 0;
        #2;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1;
        m_big = mreset();
        m_small = mreset();
        we_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (b_we) we_seen++;
        end
        chk("midrst.no_write", 32'(we_seen), 0);
        idle_inputs();
        tick();

        // Randomized sessions
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 19) == 0);
            finish = ($urandom_range(0, 24) == 0);
            req_valid = ($urandom_range(0, 9) < 7);
            req_op = 4'($urandom_range(0, 15));
            req_rd = 5'($urandom);
            req_rs1 = 5'($urandom);
            req_rs2 = 5'($urandom);
            req_imm = $urandom;
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
